// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle control unit for the 16-bit accumulator datapath
module mc_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        addr_src,
   output logic        ir_ld,
   output logic        mdr_ld,
   output logic        pc_ld,
   output logic        acc_ld,
   output logic        pc_src,
   output logic        acc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [3:0]  state,
   output logic [15:0] instr_count
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMRD  = 4'd2;
   localparam logic [3:0] S_EXEC   = 4'd3;
   localparam logic [3:0] S_LOAD   = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_JUMP   = 4'd6;
   localparam logic [3:0] S_BRANCH = 4'd7;

   localparam logic [2:0] OP_LDA = 3'b000;
   localparam logic [2:0] OP_STA = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_JMP = 3'b110;

   // active stays low until the first edge after reset release, keeping every strobe quiet until then
   logic       active;
   logic       retire;
   logic [3:0] next_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         active      <= 1'b0;
         instr_count <= 16'd0;
      end else begin
         active <= 1'b1;
         state  <= next_state;
         if (retire)
            instr_count <= instr_count + 16'd1;
      end
   end

   always_comb begin
      next_state = S_FETCH;
      if (active) begin
         case (state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (opcode)
                  OP_STA:  next_state = S_MEMWR;
                  OP_NOT:  next_state = S_EXEC;
                  OP_JMP:  next_state = S_JUMP;
                  3'b111:  next_state = S_BRANCH;
                  default: next_state = S_MEMRD;
               endcase
            end
            S_MEMRD:  next_state = !mem_ready ? S_MEMRD :
                                   (opcode == OP_LDA) ? S_LOAD : S_EXEC;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            default:  next_state = S_FETCH;
         endcase
      end
   end

   always_comb begin
      retire = 1'b0;
      if (active) begin
         case (state)
            S_EXEC, S_LOAD, S_JUMP, S_BRANCH: retire = 1'b1;
            S_MEMWR:                          retire = mem_ready;
            default:                          retire = 1'b0;
         endcase
      end
   end

   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      addr_src  = 1'b0;
      ir_ld     = 1'b0;
      mdr_ld    = 1'b0;
      pc_ld     = 1'b0;
      acc_ld    = 1'b0;
      pc_src    = 1'b0;
      acc_src   = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      if (active) begin
         case (state)
            S_FETCH: begin
               mem_rd    = 1'b1;
               alu_src_b = 2'b01;
               ir_ld     = mem_ready;
               pc_ld     = mem_ready;
            end
            S_MEMRD: begin
               mem_rd   = 1'b1;
               addr_src = 1'b1;
               mdr_ld   = mem_ready;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               acc_ld    = 1'b1;
               case (opcode)
                  OP_SUB:  alu_op = 2'b01;
                  OP_AND:  alu_op = 2'b10;
                  OP_NOT:  alu_op = 2'b11;
                  default: alu_op = 2'b00;
               endcase
            end
            S_LOAD: begin
               acc_ld  = 1'b1;
               acc_src = 1'b1;
            end
            S_MEMWR: begin
               mem_wr   = 1'b1;
               addr_src = 1'b1;
            end
            S_JUMP: begin
               pc_ld  = 1'b1;
               pc_src = 1'b1;
            end
            S_BRANCH: begin
               // ALU passes ACC through (ACC + 0) so zero reflects the accumulator
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               pc_src    = 1'b1;
               pc_ld     = ~zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the 16-bit accumulator datapath; it sits directly upstream of the ALU and drives its operation select and operand muxes. It sequences fetch, decode, memory access, execute and PC update per instruction. It also consumes the ALU zero flag for conditional branches, and it exposes a retired-instruction counter.

## Interface
- No parameters. Data width is fixed at 16, opcode at 3 bits (instr[15:13]), and address field at 13 bits (instr[12:0]).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  3  IR[15:13] from the IR register.
- zero  in  1  ALU flag: 1 = ALU result nonzero, 0 = result is zero.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_rd, mem_wr  out  1  memory strobes.
- addr_src  out  1  0 = PC, 1 = IR[12:0].
- ir_ld, mdr_ld, pc_ld, acc_ld  out  1  register load enables.
- pc_src  out  1  0 = ALU result, 1 = IR[12:0].
- acc_src  out  1  0 = ALU result, 1 = MDR.
- alu_src_a  out  1  0 = PC, 1 = ACC.
- alu_src_b  out  2  00 = MDR, 01 = constant 1, 10 = constant 0, 11 is reserved and never driven.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 not-A.
- state  out  4  current state, for debug.
- instr_count  out  16  number of retired instructions.

## Operation
- Opcodes:
  - 000 LDA: ACC<=M[a]
  - 001 STA: M[a]<=ACC
  - 010 ADD
  - 011 SUB
  - 100 AND (ADD/SUB/AND compute ACC op M[a])
  - 101 NOT: ACC<=~ACC
  - 110 JMP: PC<=a
  - 111 JZ: PC<=a if ACC==0
- State encodings: FETCH=0, DECODE=1, MEMRD=2, EXEC=3, LOAD=4, MEMWR=5, JUMP=6, BRANCH=7. Codes 8–15 are illegal and go to FETCH on the next edge.
- Outputs are decoded from the state (plus opcode, zero and mem_ready where listed). Any output not listed for a state is 0.
- FETCH:
  - mem_rd=1, addr_src=0.
  - alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0.
  - ir_ld and pc_ld are 1 only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: all enables 0. Next state by opcode:
  - 000, 010, 011, 100 -> MEMRD
  - 001 -> MEMWR
  - 101 -> EXEC
  - 110 -> JUMP
  - 111 -> BRANCH
- MEMRD:
  - mem_rd=1, addr_src=1, mdr_ld=mem_ready.
  - Holds while mem_ready=0.
  - Then goes to LOAD if opcode=000, else EXEC.
- EXEC:
  - alu_src_a=1, alu_src_b=00, acc_ld=1, acc_src=0.
  - alu_op: 010->00, 011->01, 100->10, 101->11.
  - Next state FETCH.
- LOAD: acc_ld=1, acc_src=1; next state FETCH.
- MEMWR:
  - mem_wr=1, addr_src=1.
  - Holds while mem_ready=0; then FETCH.
- JUMP: pc_ld=1, pc_src=1; next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=10, alu_op=00 (ALU result = ACC).
  - pc_src=1, pc_ld=~zero.
  - Next state FETCH.
- Retire: instr_count increments by 1 on every edge that moves from EXEC, LOAD, JUMP or BRANCH into FETCH. It also increments on the edge that leaves MEMWR with mem_ready=1. It wraps from 16'hFFFF to 0.
- Reset (rst_n low):
  - Immediately: state=FETCH, instr_count=0, all control outputs forced to 0, including mem_rd.
  - Normal FETCH behaviour starts on the first edge after rst_n rises.
  - Reset asserted mid-instruction abandons that instruction without retiring it.

## Timing
- Cycles per instruction with mem_ready tied to 1: LDA/ADD/SUB/AND = 4; STA/NOT/JMP/JZ = 3.
- Each memory wait cycle adds exactly 1 cycle in FETCH, MEMRD or MEMWR.
- A load enable is never asserted in a wait cycle, so the PC increments exactly once per fetch.
- The register updated by a load enable takes its new value on the same clock edge that leaves the state asserting it.
- zero is sampled combinationally during the single BRANCH cycle only.

## Test plan
- Reset mid-MEMRD (opcode 010, mem_ready=0), release -> state=0 and instr_count=0 asynchronously; mem_rd=1 on the first cycle after release.
- mem_ready=1 throughout, ADD (opcode 010) -> state sequence 0,1,2,3,0; alu_op=00 and acc_ld=1 in EXEC; pc_ld=1 only in FETCH; instr_count +1.
- FETCH with mem_ready low for 3 cycles -> mem_rd=1 held for 4 cycles; ir_ld/pc_ld pulse only in the 4th cycle.
- JZ with zero=0 -> pc_ld=1, pc_src=1 in BRANCH. JZ with zero=1 -> pc_ld=0. Both retire in 3 cycles.
- Sequence LDA, STA, SUB, NOT, JMP -> alu_op=01 in SUB's EXEC and 11 in NOT's EXEC; mem_wr only in MEMWR; instr_count=5 after 17 cycles.
- Preload instr_count to 16'hFFFF (retire 65535 NOT instructions), then one more NOT -> instr_count=0.
